// File: rtl/icache_pkg.sv
// Shared definitions for the direct-mapped instruction cache:
// default geometry, the refill state encoding and the NOP returned while refilling.
package icache_pkg;

    localparam int DEF_SETS       = 16;
    localparam int DEF_WORDS      = 4;
    localparam int DEF_ADDR_WIDTH = 32;

    // Byte offset inside a 32-bit word; always two bits.
    localparam int OFFSET_W = 2;

    // Field widths for the default geometry (2/2/4/24 split of a 32-bit PC).
    localparam int DEF_WORD_W  = $clog2(DEF_WORDS);
    localparam int DEF_INDEX_W = $clog2(DEF_SETS);
    localparam int DEF_TAG_W   = DEF_ADDR_WIDTH - DEF_INDEX_W - DEF_WORD_W - OFFSET_W;

    // addi x0, x0, 0 -- a harmless, deterministic instruction while stalled.
    localparam logic [31:0] NOP = 32'h00000013;

    typedef enum logic {
        IDLE   = 1'b0,
        REFILL = 1'b1
    } icache_state_t;

endpackage

// File: rtl/icache_refill_fsm.sv
// Refill controller: tracks IDLE/REFILL, the latched line, the beat counter
// and a pending flush, drives the memory request and produces the write
// strobes for the tag/data/valid storage held in icache_fetch.
module icache_refill_fsm
    import icache_pkg::*;
#(
    parameter int SETS           = DEF_SETS,
    parameter int WORDS_PER_LINE = DEF_WORDS,
    parameter int ADDR_WIDTH     = DEF_ADDR_WIDTH,
    localparam int WORD_W        = $clog2(WORDS_PER_LINE),
    localparam int INDEX_W       = $clog2(SETS),
    localparam int LINE_W        = WORD_W + OFFSET_W,
    localparam int LINE_HI_W     = ADDR_WIDTH - LINE_W,
    localparam int TAG_W         = LINE_HI_W - INDEX_W
)(
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  hit,
    input  logic [LINE_HI_W-1:0]  pc_line,
    input  logic                  fence_i,
    input  logic                  mem_valid,
    output logic                  refilling,
    output logic                  start,
    output logic                  mem_req,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic                  wr_en,
    output logic [INDEX_W-1:0]    wr_index,
    output logic [WORD_W-1:0]     wr_word,
    output logic [TAG_W-1:0]      wr_tag,
    output logic                  last_beat,
    output logic                  set_valid,
    output logic                  flush_all
);

    icache_state_t         state_reg;
    logic [WORD_W-1:0]     beat_cnt_reg;
    logic [LINE_HI_W-1:0]  line_reg;
    logic                  flush_pending_reg;
    logic                  mem_req_reg;
    logic [ADDR_WIDTH-1:0] mem_addr_reg;
    logic                  flush_now;

    assign refilling = (state_reg == REFILL);
    assign start     = !refilling && !hit;
    assign wr_en     = refilling && mem_valid;
    assign last_beat = wr_en && (beat_cnt_reg == WORD_W'(WORDS_PER_LINE - 1));
    // A fence arriving on the final beat itself is honoured like a pending one.
    assign flush_now = flush_pending_reg || fence_i;
    assign set_valid = last_beat && !flush_now;
    assign flush_all = (!refilling && fence_i) || (last_beat && flush_now);
    assign wr_index  = line_reg[INDEX_W-1:0];
    assign wr_tag    = line_reg[LINE_HI_W-1:INDEX_W];
    assign wr_word   = beat_cnt_reg;
    assign mem_req   = mem_req_reg;
    assign mem_addr  = mem_addr_reg;

    // State, beat counter, latched line and registered memory request.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg         <= IDLE;
            beat_cnt_reg      <= '0;
            line_reg          <= '0;
            flush_pending_reg <= 1'b0;
            mem_req_reg       <= 1'b0;
            mem_addr_reg      <= '0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (!hit) begin
                        state_reg         <= REFILL;
                        line_reg          <= pc_line;
                        beat_cnt_reg      <= '0;
                        flush_pending_reg <= 1'b0;
                        mem_req_reg       <= 1'b1;
                        mem_addr_reg      <= {pc_line, {LINE_W{1'b0}}};
                    end
                end
                REFILL: begin
                    if (fence_i) begin
                        flush_pending_reg <= 1'b1;
                    end
                    if (mem_valid) begin
                        if (beat_cnt_reg == WORD_W'(WORDS_PER_LINE - 1)) begin
                            state_reg         <= IDLE;
                            beat_cnt_reg      <= '0;
                            flush_pending_reg <= 1'b0;
                            mem_req_reg       <= 1'b0;
                        end else begin
                            beat_cnt_reg <= beat_cnt_reg + WORD_W'(1);
                            mem_addr_reg <= {line_reg, beat_cnt_reg + WORD_W'(1),
                                             {OFFSET_W{1'b0}}};
                        end
                    end
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

endmodule

// File: rtl/icache_fetch.sv
// Direct-mapped read-only instruction cache. Hits return the instruction
// combinationally; misses stall and refill one line beat by beat.
// Optional hit/miss counters are built when ICACHE_STATS_EN is defined.
module icache_fetch
    import icache_pkg::*;
#(
    parameter int SETS           = DEF_SETS,
    parameter int WORDS_PER_LINE = DEF_WORDS,
    parameter int ADDR_WIDTH     = DEF_ADDR_WIDTH
)(
    input  logic                  clk,
    input  logic                  rst,
    input  logic [ADDR_WIDTH-1:0] pc,
    input  logic                  fence_i,
    output logic [31:0]           instr,
    output logic                  stall,
    output logic                  mem_req,
    output logic [ADDR_WIDTH-1:0] mem_addr,
`ifdef ICACHE_STATS_EN
    output logic [31:0]           hit_count,
    output logic [31:0]           miss_count,
`endif
    input  logic                  mem_valid,
    input  logic [31:0]           mem_rdata
);

    localparam int WORD_W    = $clog2(WORDS_PER_LINE);
    localparam int INDEX_W   = $clog2(SETS);
    localparam int LINE_W    = WORD_W + OFFSET_W;
    localparam int LINE_HI_W = ADDR_WIDTH - LINE_W;
    localparam int TAG_W     = LINE_HI_W - INDEX_W;

    logic [WORD_W-1:0]  pc_word;
    logic [INDEX_W-1:0] pc_index;
    logic [TAG_W-1:0]   pc_tag;
    logic               hit;
    logic               refilling, start, wr_en, last_beat, set_valid, flush_all;
    logic [INDEX_W-1:0] wr_index;
    logic [WORD_W-1:0]  wr_word;
    logic [TAG_W-1:0]   wr_tag;
    logic               unused_pc_bits;

    logic               valid_reg [SETS];
    logic [TAG_W-1:0]   tag_mem   [SETS];
    logic [31:0]        data_mem  [SETS*WORDS_PER_LINE];

    assign pc_word        = pc[OFFSET_W +: WORD_W];
    assign pc_index       = pc[LINE_W +: INDEX_W];
    assign pc_tag         = pc[ADDR_WIDTH-1:LINE_W+INDEX_W];
    assign unused_pc_bits = &{1'b0, pc[OFFSET_W-1:0]};

    assign hit   = valid_reg[pc_index] && (tag_mem[pc_index] == pc_tag);
    assign stall = refilling || !hit;
    assign instr = refilling ? NOP : data_mem[{pc_index, pc_word}];

    icache_refill_fsm #(
        .SETS           (SETS),
        .WORDS_PER_LINE (WORDS_PER_LINE),
        .ADDR_WIDTH     (ADDR_WIDTH)
    ) u_refill (
        .clk       (clk),
        .rst       (rst),
        .hit       (hit),
        .pc_line   (pc[ADDR_WIDTH-1:LINE_W]),
        .fence_i   (fence_i),
        .mem_valid (mem_valid),
        .refilling (refilling),
        .start     (start),
        .mem_req   (mem_req),
        .mem_addr  (mem_addr),
        .wr_en     (wr_en),
        .wr_index  (wr_index),
        .wr_word   (wr_word),
        .wr_tag    (wr_tag),
        .last_beat (last_beat),
        .set_valid (set_valid),
        .flush_all (flush_all)
    );

    // Refill beats land in the data array; contents are never reset.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            data_mem[{wr_index, wr_word}] <= mem_rdata;
        end
    end

    // The tag is committed with the final beat of the line.
    always_ff @(posedge clk) begin
        if (last_beat) begin
            tag_mem[wr_index] <= wr_tag;
        end
    end

    // One valid bit per line: cleared by reset or flush, set on a clean refill.
    for (genvar gi = 0; gi < SETS; gi++) begin : g_valid
        always_ff @(posedge clk) begin
            if (rst || flush_all) begin
                valid_reg[gi] <= 1'b0;
            end else if (set_valid && (wr_index == INDEX_W'(gi))) begin
                valid_reg[gi] <= 1'b1;
            end
        end
    end

`ifdef ICACHE_STATS_EN
    logic [31:0] hit_count_reg;
    logic [31:0] miss_count_reg;

    // Hit cycles in IDLE and IDLE->REFILL transitions; fence_i does not touch them.
    always_ff @(posedge clk) begin
        if (rst) begin
            hit_count_reg  <= '0;
            miss_count_reg <= '0;
        end else begin
            if (!refilling && hit) begin
                hit_count_reg <= hit_count_reg + 32'd1;
            end
            if (start) begin
                miss_count_reg <= miss_count_reg + 32'd1;
            end
        end
    end

    assign hit_count  = hit_count_reg;
    assign miss_count = miss_count_reg;
`endif

endmodule

// File: tb/tb_icache_fetch.sv
// Directed testbench for icache_fetch (default 16 sets x 4 words, 32-bit PC).
module tb_icache_fetch;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] pc;
    logic        fence_i;
    logic [31:0] instr;
    logic        stall;
    logic        mem_req;
    logic [31:0] mem_addr;
    logic        mem_valid;
    logic [31:0] mem_rdata;
`ifdef ICACHE_STATS_EN
    logic [31:0] hit_count;
    logic [31:0] miss_count;
`endif

    int n_cmp = 0;
    int n_bad = 0;
    int gen   = 0;

    always #5 clk = ~clk;

    icache_fetch dut (
        .clk        (clk),
        .rst        (rst),
        .pc         (pc),
        .fence_i    (fence_i),
        .instr      (instr),
        .stall      (stall),
        .mem_req    (mem_req),
        .mem_addr   (mem_addr),
`ifdef ICACHE_STATS_EN
        .hit_count  (hit_count),
        .miss_count (miss_count),
`endif
        .mem_valid  (mem_valid),
        .mem_rdata  (mem_rdata)
    );

    // Memory image: word at byte address a is (0xA0 + a/4) ^ (gen << 16).
    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return (32'hA0 + (a >> 2)) ^ (32'(gen) << 16);
    endfunction

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        assert (got === exp) else begin
            n_bad++;
            $error("FAIL %s: got %h expected %h", name, got, exp);
        end
        $display("check %-16s got %h expected %h", name, got, exp);
    endtask

    task automatic cyc();
        @(posedge clk);
        #2;
    endtask

    // Entered in the IDLE miss cycle; serves one line and returns in the first IDLE cycle after it.
    task automatic refill(input logic [31:0] base, input bit gaps, input int fence_beat,
                          input int exp_stall);
        int stalls;
        int beat;
        int n;
        bit g;
        stalls = 1;
        beat   = 0;
        n      = 0;
        g      = gaps;
        chk("miss_stall", {31'd0, stall}, 32'd1);
        while (beat < 4 && n < 40) begin
            cyc();
            n++;
            fence_i = 1'b0;
            #1;
            chk("refill_stall", {31'd0, stall}, 32'd1);
            chk("refill_req", {31'd0, mem_req}, 32'd1);
            chk("refill_addr", mem_addr, base + 32'(4 * beat));
            chk("refill_nop", instr, 32'h00000013);
            stalls++;
            if (g) begin
                mem_valid = 1'b0;
            end else begin
                mem_valid = 1'b1;
                mem_rdata = mem_word(base + 32'(4 * beat));
                if (beat == fence_beat) fence_i = 1'b1;
                beat++;
            end
            if (gaps) g = ~g;
        end
        cyc();
        mem_valid = 1'b0;
        fence_i   = 1'b0;
        #1;
        chk("refill_done_req", {31'd0, mem_req}, 32'd0);
        chk("refill_beats", 32'(beat), 32'd4);
        chk("stall_cycles", 32'(stalls), 32'(exp_stall));
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst       = 1'b1;
        pc        = 32'h0;
        fence_i   = 1'b0;
        mem_valid = 1'b0;
        mem_rdata = 32'h0;
        cyc();
        cyc();
        #1;
        chk("rst_mem_req", {31'd0, mem_req}, 32'd0);
        chk("rst_mem_addr", mem_addr, 32'h0);
        chk("rst_cold_stall", {31'd0, stall}, 32'd1);
`ifdef ICACHE_STATS_EN
        chk("rst_hits", hit_count, 32'd0);
        chk("rst_misses", miss_count, 32'd0);
`endif

        // Cold miss on line 0, back-to-back beats.
        rst = 1'b0;
        #1;
        gen = 0;
        refill(32'h0, 1'b0, -1, 5);
        chk("cold_instr", instr, 32'h000000A0);
        chk("cold_stall", {31'd0, stall}, 32'd0);

`ifdef ICACHE_STATS_EN
        chk("st_miss1", miss_count, 32'd1);
        chk("st_hit0", hit_count, 32'd0);
        cyc();
        cyc();
        cyc();
        #1;
        chk("st_hit3", hit_count, 32'd3);
        chk("st_miss1b", miss_count, 32'd1);
        fence_i = 1'b1;
        cyc();
        fence_i = 1'b0;
        #1;
        chk("st_fence_hit", hit_count, 32'd4);
        chk("st_fence_miss", miss_count, 32'd1);
        refill(32'h0, 1'b0, -1, 5);
`endif

        pc = 32'h8;
        #1;
        chk("hit_word2", instr, 32'h000000A2);
        chk("hit_word2_stall", {31'd0, stall}, 32'd0);

        // Conflict: 0x100 shares index 0 with a different tag.
        pc = 32'h100;
        #1;
        refill(32'h100, 1'b0, -1, 5);
        chk("conflict_instr", instr, 32'h000000E0);
        pc = 32'h0;
        #1;
        // Line 0 was evicted; refill it again with gaps between beats.
        gen = 1;
        refill(32'h0, 1'b1, -1, 9);
        chk("gap_instr0", instr, 32'h000100A0);
        pc = 32'hC;
        #1;
        chk("gap_instr3", instr, 32'h000100A3);
        pc = 32'h100;
        #1;
        chk("evicted_stall", {31'd0, stall}, 32'd1);
        pc = 32'hC;
        #1;
        chk("gap_hit_stall", {31'd0, stall}, 32'd0);

        // fence_i during beat 2: refill completes but the line stays invalid.
        pc  = 32'h40;
        gen = 3;
        #1;
        refill(32'h40, 1'b0, 2, 5);
        chk("fence_remiss", {31'd0, stall}, 32'd1);
        refill(32'h40, 1'b0, -1, 5);
        chk("fence_refill", instr, 32'h000300B0);
        chk("fence_hit", {31'd0, stall}, 32'd0);
        pc = 32'h0;
        #1;
        chk("fence_flushed0", {31'd0, stall}, 32'd1);
        pc = 32'h40;
        #1;

        // fence_i in IDLE: same cycle still hits, next cycle misses.
        fence_i = 1'b1;
        #1;
        chk("idle_fence_hit", {31'd0, stall}, 32'd0);
        cyc();
        fence_i = 1'b0;
        #1;
        chk("idle_fence_miss", {31'd0, stall}, 32'd1);
        refill(32'h40, 1'b0, -1, 5);
        chk("idle_fence_fill", instr, 32'h000300B0);
`ifdef ICACHE_STATS_EN
        chk("st_miss_total", miss_count, 32'd7);
`endif

        // Reset after beat 1 of a refill.
        pc = 32'h80;
        gen = 4;
        #1;
        chk("rstmid_miss", {31'd0, stall}, 32'd1);
        cyc();
        mem_valid = 1'b1;
        mem_rdata = mem_word(32'h80);
        cyc();
        mem_rdata = mem_word(32'h84);
        cyc();
        mem_valid = 1'b0;
        rst = 1'b1;
        #1;
        chk("rstmid_req_before", {31'd0, mem_req}, 32'd1);
        chk("rstmid_addr_before", mem_addr, 32'h88);
        cyc();
        rst = 1'b0;
        pc  = 32'h0;
        #1;
        chk("rstmid_req", {31'd0, mem_req}, 32'd0);
        chk("rstmid_addr", mem_addr, 32'h0);
        chk("rstmid_pc0_miss", {31'd0, stall}, 32'd1);
`ifdef ICACHE_STATS_EN
        chk("rstmid_hits", hit_count, 32'd0);
        chk("rstmid_misses", miss_count, 32'd0);
`endif
        cyc();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/icache_fetch.md
Name: icache_fetch

Overview:
- Direct-mapped, read-only instruction cache between the PC register and the decode stage.
- Takes the current PC value each cycle and, on a hit, returns the instruction combinationally in the same cycle.
- On a miss it asserts stall, so the PC holds and the fetch pipeline register freezes, and refills one line from main memory through a valid/ready-style beat interface.
- fence_i invalidates the whole cache.

Parameters:
- SETS, 16, number of lines; power of two, at least 2.
- WORDS_PER_LINE, 4, 32-bit words per line; power of two, at least 2.
- ADDR_WIDTH, 32, width of the PC and memory address.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  synchronous, active-high reset.
- pc  in  ADDR_WIDTH  fetch address from the PC register; pc[1:0] ignored.
- fence_i  in  1  invalidate all lines.
- instr  out  32  instruction at pc; valid only when stall=0.
- stall  out  1  miss/refill in progress; PC and IF/ID must hold.
- mem_req  out  1  refill request, held high for the whole refill.
- mem_addr  out  ADDR_WIDTH  word address of the beat currently requested.
- mem_valid  in  1  memory presents one word this cycle.
- mem_rdata  in  32  refill word.

Behaviour:
- Address split: byte offset [1:0]; word = next log2(WORDS_PER_LINE) bits; index = next log2(SETS) bits; tag = remaining upper bits. Defaults give 2/2/4/24.
- Storage per line: valid bit, tag, and WORDS_PER_LINE data words.
- hit = valid[index] && tag_store[index]==tag.
- States: IDLE and REFILL.
- IDLE:
  - instr = data[index][word] combinationally.
  - stall = ~hit.
  - On a miss: latch the line base (pc with word and offset bits zeroed), clear beat_cnt, go to REFILL at the next edge.
  - A miss costs at least WORDS_PER_LINE+1 stalled cycles.
- REFILL:
  - stall=1, mem_req=1, mem_addr = base + 4*beat_cnt.
  - Each mem_valid cycle: write mem_rdata into data[latched index][beat_cnt], increment beat_cnt.
  - mem_valid low: hold everything; no timeout.
  - On the final beat (beat_cnt==WORDS_PER_LINE-1 with mem_valid): write the tag, set valid unless a flush is pending, go to IDLE.
  - The first IDLE cycle re-evaluates the current pc; it normally hits with stall=0.
- pc changing during REFILL: ignored; the refill always completes for the latched line.
- mem_req and mem_addr are registered; mem_req deasserts at the edge that accepts the final beat.
- instr in REFILL: don't-care, but must be a deterministic value (drive 32'h00000013, NOP).
- fence_i in IDLE: all valid bits clear at the next edge. The same cycle still reports hit/miss against the old contents; any miss seen that cycle still starts a refill.
- fence_i in REFILL: sets flush_pending. On the final beat all valid bits clear and the refilled line is not marked valid; flush_pending clears. The following IDLE cycle therefore misses again.
- rst, which has priority over everything including mid-refill:
  - state=IDLE, all valid bits 0, beat_cnt=0, flush_pending=0, mem_req=0, mem_addr=0.
  - Data and tag arrays are not reset.
  - stall after reset = 1 for any pc (cold miss).

Optional Feature:
- Macro: ICACHE_STATS_EN.
- When defined, adds two outputs, hit_count [31:0] and miss_count [31:0].
  - hit_count increments on each IDLE cycle with hit and no rst.
  - miss_count increments on each IDLE→REFILL transition.
  - Both wrap at 2^32, clear on rst, and are unaffected by fence_i.
- When undefined, the ports and counters are absent; behaviour is otherwise identical.

Decomposition:
- Shared package icache_pkg holds:
  - localparams for field widths derived from SETS/WORDS_PER_LINE;
  - state enum icache_state_t {IDLE, REFILL};
  - NOP constant 32'h00000013.
- One natural sub-module, icache_refill_fsm: owns state, beat_cnt, base, flush_pending and the mem_* outputs. It emits write-enable, index and word-select signals to the storage arrays in icache_fetch.

Test Plan:
- Cold miss after rst, pc=0x0000_0000; memory returns 0xA0,0xA1,0xA2,0xA3 with mem_valid every cycle -> stall=1 for 5 cycles; mem_addr sequence 0x0,0x4,0x8,0xC; then instr=0xA0, stall=0; pc=0x8 gives instr=0xA2 with no stall.
- Beat gaps: same refill with mem_valid low on alternate cycles -> mem_addr holds across gaps; final contents are correct; stall lasts 9 cycles.
- Conflict: fill pc=0x0, then pc=0x100 (same index 0, different tag) -> miss and refill; after it, pc=0x0 misses again.
- fence_i mid-refill: asserted during beat 2 -> refill completes; the next IDLE cycle still misses on the same pc and refills again.
- rst mid-refill: after beat 1 -> next cycle mem_req=0, state IDLE, and pc=0x0 misses.
- ICACHE_STATS_EN build: 1 miss then 3 hit cycles -> miss_count=1, hit_count=3; fence_i leaves both counters unchanged.
